// File: rtl/sop_sync_pkg.sv
// Shared types and helpers for the SOP sync tracker.
//  - sop_state_t : tracker FSM state encoding (SEARCH / TRACK / LOCKED)
//  - CNT_MAX/CNT_W : default confidence saturation value and counter width
//  - off_width()   : width of the signed timing-offset output
//  - frame_len()   : frame length in samples from symbol count and symbol length
package sop_sync_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } sop_state_t;

   localparam int unsigned CNT_MAX = 20;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   // Signed offset must hold -WIN..+WIN.
   function automatic int unsigned off_width(input int unsigned win);
      return $clog2(win) + 2;
   endfunction

   function automatic int unsigned frame_len(input int unsigned n_symb,
                                             input int unsigned sym_len);
      return n_symb * sym_len;
   endfunction

endpackage

// File: rtl/sop_conf_counter.sv
// Saturating up/down confidence counter with hysteresis compares.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  clr           force count to 0
//  load_one      force count to 1 (new frame anchor)
//  inc, dec      saturating increment (to CNT_MAX) / decrement (to 0)
//  conf          current count
//  above_up      conf > TSHD_UP
//  below_dw      conf < TSHD_DW
//  zero          conf == 0
module sop_conf_counter #(
   parameter int unsigned CNT_MAX = 20,
   parameter int unsigned TSHD_UP = 15,
   parameter int unsigned TSHD_DW = 7,
   parameter int unsigned W       = $clog2(CNT_MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load_one,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] conf,
   output logic         above_up,
   output logic         below_dw,
   output logic         zero
);

   // Priority: clear, anchor load, increment, decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         conf <= '0;
      end else if (clr) begin
         conf <= '0;
      end else if (load_one) begin
         conf <= W'(1);
      end else if (inc) begin
         if (conf < W'(CNT_MAX)) conf <= conf + W'(1);
      end else if (dec) begin
         if (conf != '0) conf <= conf - W'(1);
      end
   end

   assign above_up = (conf > W'(TSHD_UP));
   assign below_dw = (conf < W'(TSHD_DW));
   assign zero     = (conf == '0);

endmodule

// File: rtl/sop_sync_tracker.sv
// Frame-level start-of-packet tracker. Qualifies raw SOP pulses by metric,
// confirms them against a runtime frame period, tracks the per-frame offset
// and regenerates a periodic osop flywheel while locked.
// Optional statistics counters are built when SOP_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
// Ports:
//  clk, rst                   clock, synchronous active-high reset
//  cfg_n_symb                 symbols per frame (latched in SEARCH only)
//  cfg_met_lo, cfg_met_hi     inclusive accepted metric range (latched in SEARCH only)
//  isop, i_metric             raw SOP pulse and its correlation metric
//  osop                       regenerated 1-cycle SOP
//  delay_sop                  signed offset of last hit vs nominal SOP
//  found_sync                 high while LOCKED
//  state                      0 SEARCH, 1 TRACK, 2 LOCKED
//  stat_hit/stat_miss/stat_loss  saturating 16-bit statistics
module sop_sync_tracker
   import sop_sync_pkg::*;
#(
   parameter int unsigned FFT_SIZE = 1024,
   parameter int unsigned CP_SIZE  = 32,
   parameter int unsigned MAX_SYMB = 64,
   parameter int unsigned WIN      = 3,
   parameter int unsigned CNT_MAX  = 20,
   parameter int unsigned TSHD_UP  = 15,
   parameter int unsigned TSHD_DW  = 7,
   parameter int unsigned MET_W    = 15
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [$clog2(MAX_SYMB+1)-1:0]          cfg_n_symb,
   input  logic [MET_W-1:0]                       cfg_met_lo,
   input  logic [MET_W-1:0]                       cfg_met_hi,
   input  logic                                   isop,
   input  logic [MET_W-1:0]                       i_metric,
   output logic                                   osop,
   output logic signed [off_width(WIN)-1:0]       delay_sop,
   output logic                                   found_sync,
   output logic [1:0]                             state,
   output logic [15:0]                            stat_hit,
   output logic [15:0]                            stat_miss,
   output logic [15:0]                            stat_loss
);

   localparam int unsigned SYM_LEN = FFT_SIZE + CP_SIZE;
   localparam int unsigned L_MAX   = MAX_SYMB * SYM_LEN;
   localparam int unsigned LEN_W   = $clog2(L_MAX + 1);
   localparam int unsigned OW      = off_width(WIN);
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   sop_state_t              state_r, state_nxt;
   logic [LEN_W-1:0]        count_fr, count_nxt;
   logic [LEN_W-1:0]        len_r;
   logic [MET_W-1:0]        met_lo_r, met_hi_r;
   logic                    hit_flag, hit_flag_nxt;
   logic signed [OW-1:0]    delay_nxt;
   logic                    osop_nxt;

   logic                    in_search, q, in_win;
   logic                    acquire, hit, reanchor, anchor, eval, miss_dec, drop;
   logic [MET_W-1:0]        met_lo_eff, met_hi_eff;
   logic signed [LEN_W:0]   late_off;
   logic [CW-1:0]           conf;
   logic                    above_up, below_dw, zero;

   assign state = state_r;

   // In SEARCH the live config applies; elsewhere the copy latched on leaving SEARCH.
   assign in_search  = (state_r == ST_SEARCH);
   assign met_lo_eff = in_search ? cfg_met_lo : met_lo_r;
   assign met_hi_eff = in_search ? cfg_met_hi : met_hi_r;
   assign q          = isop && (i_metric >= met_lo_eff) && (i_metric <= met_hi_eff);

   assign in_win   = (count_fr >= len_r - LEN_W'(WIN)) || (count_fr <= LEN_W'(WIN));
   assign acquire  = in_search && q;
   assign hit      = !in_search && q && in_win;
   // With no confidence left, an out-of-window pulse restarts the frame timing.
   assign reanchor = (state_r == ST_TRACK) && q && !in_win && zero;
   assign anchor   = hit || reanchor;
   // Once-per-frame miss evaluation; an anchor in the same cycle takes precedence.
   assign eval     = !in_search && (count_fr == LEN_W'(WIN + 1)) && !anchor;
   assign miss_dec = eval && !hit_flag && !zero;
   assign drop     = (state_r == ST_TRACK) && eval && !hit_flag && zero;
   assign late_off = $signed({1'b0, count_fr}) - $signed({1'b0, len_r});

   sop_conf_counter #(
      .CNT_MAX (CNT_MAX),
      .TSHD_UP (TSHD_UP),
      .TSHD_DW (TSHD_DW),
      .W       (CW)
   ) u_conf (
      .clk      (clk),
      .rst      (rst),
      .clr      (in_search && !acquire),
      .load_one (acquire || reanchor),
      .inc      (hit),
      .dec      (miss_dec),
      .conf     (conf),
      .above_up (above_up),
      .below_dw (below_dw),
      .zero     (zero)
   );

   // Next-state, frame counter, hit flag, offset and flywheel pulse.
   always_comb begin
      state_nxt    = state_r;
      count_nxt    = count_fr;
      hit_flag_nxt = hit_flag;
      delay_nxt    = delay_sop;
      osop_nxt     = (state_r == ST_LOCKED) && (count_fr == LEN_W'(WIN + 1));

      case (state_r)
         ST_SEARCH: if (acquire) state_nxt = ST_TRACK;
         ST_TRACK: begin
            if (above_up)  state_nxt = ST_LOCKED;
            else if (drop) state_nxt = ST_SEARCH;
         end
         ST_LOCKED: if (below_dw) state_nxt = ST_TRACK;
         default:   state_nxt = ST_SEARCH;
      endcase

      if (in_search) begin
         count_nxt    = acquire ? LEN_W'(1) : '0;
         hit_flag_nxt = acquire;
      end else if (state_nxt == ST_SEARCH) begin
         count_nxt    = '0;
         hit_flag_nxt = 1'b0;
      end else begin
         if (anchor)                              count_nxt = LEN_W'(1);
         else if (count_fr >= len_r - LEN_W'(1))  count_nxt = '0;
         else                                     count_nxt = count_fr + LEN_W'(1);

         if (anchor)    hit_flag_nxt = 1'b1;
         else if (eval) hit_flag_nxt = 1'b0;

         if (hit) begin
            if (count_fr <= LEN_W'(WIN)) delay_nxt = OW'(count_fr);
            else                         delay_nxt = OW'(late_off);
         end
      end
   end

   // State and datapath registers; config only follows the inputs in SEARCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_SEARCH;
         count_fr   <= '0;
         hit_flag   <= 1'b0;
         delay_sop  <= '0;
         osop       <= 1'b0;
         found_sync <= 1'b0;
         len_r      <= '0;
         met_lo_r   <= '0;
         met_hi_r   <= '0;
      end else begin
         state_r    <= state_nxt;
         count_fr   <= count_nxt;
         hit_flag   <= hit_flag_nxt;
         delay_sop  <= delay_nxt;
         osop       <= osop_nxt;
         found_sync <= (state_nxt == ST_LOCKED);
         if (in_search) begin
            len_r    <= LEN_W'(frame_len(32'(cfg_n_symb), SYM_LEN));
            met_lo_r <= cfg_met_lo;
            met_hi_r <= cfg_met_hi;
         end
      end
   end

`ifdef SOP_STATS_EN
   logic hit_evt, loss_evt;

   assign hit_evt  = acquire || anchor;
   assign loss_evt = (state_r == ST_LOCKED) && (state_nxt == ST_TRACK);

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hit  <= '0;
         stat_miss <= '0;
         stat_loss <= '0;
      end else begin
         if (hit_evt  && (stat_hit  != 16'hFFFF)) stat_hit  <= stat_hit  + 16'd1;
         if (miss_dec && (stat_miss != 16'hFFFF)) stat_miss <= stat_miss + 16'd1;
         if (loss_evt && (stat_loss != 16'hFFFF)) stat_loss <= stat_loss + 16'd1;
      end
   end
`else
   assign stat_hit  = 16'd0;
   assign stat_miss = 16'd0;
   assign stat_loss = 16'd0;
`endif

endmodule

// File: tb/tb_sop_sync_tracker.sv
// Scoreboard bench for sop_sync_tracker with FFT_SIZE=16, CP_SIZE=4,
// cfg_n_symb=2 (L=40) and accepted metric range 15..25.
module tb_sop_sync_tracker;

   logic               clk = 1'b0;
   logic               rst;
   logic [6:0]         cfg_n_symb;
   logic [14:0]        cfg_met_lo, cfg_met_hi, i_metric;
   logic               isop;
   logic               osop;
   logic signed [3:0]  delay_sop;
   logic               found_sync;
   logic [1:0]         state;
   logic [15:0]        stat_hit, stat_miss, stat_loss;

   typedef struct {
      int cyc;
      int dly;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   sop_sync_tracker #(
      .FFT_SIZE (16),
      .CP_SIZE  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_n_symb (cfg_n_symb),
      .cfg_met_lo (cfg_met_lo),
      .cfg_met_hi (cfg_met_hi),
      .isop       (isop),
      .i_metric   (i_metric),
      .osop       (osop),
      .delay_sop  (delay_sop),
      .found_sync (found_sync),
      .state      (state),
      .stat_hit   (stat_hit),
      .stat_miss  (stat_miss),
      .stat_loss  (stat_loss)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every osop pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
         checks++;
         errors++;
         $display("FAIL osop_missing expected cyc %0d now %0d", sb[0].cyc, cyc);
         sb.delete(0);
      end
      if (!rst && osop) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL osop_unexpected at cyc %0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            if (cyc != mon_e.cyc || int'(delay_sop) != mon_e.dly || found_sync !== 1'b1) begin
               errors++;
               $display("FAIL osop got cyc %0d delay %0d found %0b, exp cyc %0d delay %0d found 1",
                        cyc, int'(delay_sop), found_sync, mon_e.cyc, mon_e.dly);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic push(input int c, input int d);
      exp_t e;
      e.cyc = c;
      e.dly = d;
      sb.push_back(e);
   endtask

   task automatic pulse(input int m);
      isop     = 1'b1;
      i_metric = 15'(m);
      tick(1);
      isop     = 1'b0;
      i_metric = '0;
   endtask

   function automatic int met_tab(input int k);
      case (k % 3)
         1:       return 15;
         2:       return 25;
         default: return 20;
      endcase
   endfunction

   function automatic int bad_tab(input int k);
      case (k % 4)
         0:       return 3;
         1:       return 30;
         2:       return 14;
         default: return 26;
      endcase
   endfunction

   initial begin
      int c;
      int c3;
      rst        = 1'b1;
      isop       = 1'b0;
      i_metric   = '0;
      cfg_n_symb = 7'd2;
      cfg_met_lo = 15'd15;
      cfg_met_hi = 15'd25;
      tick(3);
      chk("rst_state", int'(state), 0);
      chk("rst_found", int'(found_sync), 0);
      chk("rst_osop", int'(osop), 0);
      chk("rst_delay", int'(delay_sop), 0);
      rst = 1'b0;
      tick(2);

      // 1: periodic SOPs, boundary metrics 15/25 included; lock on 16th hit
      for (int k = 0; k < 20; k++) begin
         if (k == 1)  chk("t1_track", int'(state), 1);
         if (k == 15) chk("t1_found_pre", int'(found_sync), 0);
         if (k == 16) begin
            chk("t1_found", int'(found_sync), 1);
            chk("t1_locked", int'(state), 2);
         end
         c = cyc;
         if (k >= 15) push(c + 5, 0);
         pulse(met_tab(k));
         tick(39);
      end

      // 2: offsets +2, -3 (window edge), -4 (miss)
      tick(2);
      c = cyc;
      push(c + 5, 2);
      pulse(20);
      tick(36);
      c = cyc;
      push(c + 5, -3);
      pulse(20);
      tick(35);
      push(cyc + 9, -3);
      pulse(20);
      tick(43);
      chk("t2_locked", int'(state), 2);
      c = cyc;
      push(c + 5, 0);
      pulse(20);

      // 3: SOPs stop at conf=20; flywheel until lock drops after 14 frames
      c3 = c;
      for (int k = 1; k <= 14; k++) push(c3 + 40 * k + 5, 0);
      tick(c3 + 565 - cyc);
      chk("t3_found_last", int'(found_sync), 1);
      chk("t3_state_last", int'(state), 2);
      tick(1);
      chk("t3_found_drop", int'(found_sync), 0);
      chk("t3_state_drop", int'(state), 1);
`ifdef SOP_STATS_EN
      chk("t3_stat_hit", int'(stat_hit), 23);
      chk("t3_stat_miss", int'(stat_miss), 15);
      chk("t3_stat_loss", int'(stat_loss), 1);
`endif
      tick(c3 + 844 - cyc);
      chk("t3_track_end", int'(state), 1);
      tick(2);
      chk("t3_search", int'(state), 0);

      // 4: out-of-range metrics never acquire
      tick(3);
      for (int k = 0; k < 8; k++) begin
         pulse(bad_tab(k));
         chk("t4_search", int'(state), 0);
         tick(38);
      end

      // 5: relock, config change ignored while locked, reset mid-operation
      for (int k = 0; k < 16; k++) begin
         c = cyc;
         if (k == 15) push(c + 5, 0);
         pulse(20);
         tick(39);
      end
      cfg_n_symb = 7'd3;
      cfg_met_lo = 15'd21;
      tick(1);
      pulse(20);
      tick(3);
      chk("t5_delay_pre", int'(delay_sop), 1);
      chk("t5_locked_pre", int'(state), 2);
      rst = 1'b1;
      tick(1);
      chk("t5_state", int'(state), 0);
      chk("t5_found", int'(found_sync), 0);
      chk("t5_delay", int'(delay_sop), 0);
      chk("t5_osop", int'(osop), 0);
      cfg_n_symb = 7'd2;
      cfg_met_lo = 15'd15;
      tick(2);
      rst = 1'b0;
      tick(2);

      // 6: 10 hits then 3 empty frames
      for (int k = 0; k < 10; k++) begin
         pulse(20);
         tick(39);
      end
      tick(90);
      chk("t6_state", int'(state), 1);
`ifdef SOP_STATS_EN
      chk("t6_stat_hit", int'(stat_hit), 10);
      chk("t6_stat_miss", int'(stat_miss), 3);
      chk("t6_stat_loss", int'(stat_loss), 0);
`else
      chk("t6_stat_hit", int'(stat_hit), 0);
      chk("t6_stat_miss", int'(stat_miss), 0);
      chk("t6_stat_loss", int'(stat_loss), 0);
`endif

      tick(2);
      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
